// File: rtl/data_gen_mc.sv
// Multi-lane sample generator: one sample every PERIOD cycles in LFSR, increment,
// constant or walking-one mode, timestamped, delivered over valid/ready with overrun flag.
module data_gen_mc #(
  parameter int              WIDTH    = 8,
  parameter int              CHANNELS = 2,
  parameter int              PERIOD   = 10,
  parameter logic [WIDTH-1:0] SEED    = 8'hA5,
  parameter logic [WIDTH-1:0] POLY    = 8'hB8,
  parameter int              TS_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          const_val,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_W-1:0]           out_ts,
  output logic                      overrun,
  input  logic                      clr_ovr
);

  localparam int               CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  if (SEED == '0) begin : g_seed_chk
    $error("data_gen_mc: SEED must be nonzero");
  end

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [TS_W-1:0]           ts_q, ts_d;
  logic [WIDTH-1:0]          lfsr_q, lfsr_d;
  logic [WIDTH-1:0]          inc_q, inc_d;
  logic [WIDTH-1:0]          walk_q, walk_d;
  logic [CHANNELS*WIDTH-1:0] data_q, data_d;
  logic [TS_W-1:0]           ots_q, ots_d;
  logic                      valid_q, valid_d;
  logic                      ovr_q, ovr_d;

  logic                      tick, slot_free, load, drop;
  logic [WIDTH-1:0]          lane0;

  always_comb begin
    tick      = en && (cnt_q == CNT_LAST);
    slot_free = !valid_q || out_ready;
    load      = tick && slot_free;
    drop      = tick && !slot_free;

    case (mode)
      2'd0:    lane0 = lfsr_q;
      2'd1:    lane0 = inc_q;
      2'd2:    lane0 = const_val;
      default: lane0 = walk_q;
    endcase

    cnt_d   = cnt_q;
    ts_d    = ts_q + TS_W'(1);
    lfsr_d  = lfsr_q;
    inc_d   = inc_q;
    walk_d  = walk_q;
    data_d  = data_q;
    ots_d   = ots_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (!en)
      cnt_d = '0;
    else if (cnt_q == CNT_LAST)
      cnt_d = '0;
    else
      cnt_d = cnt_q + CNT_W'(1);

    if (valid_q && out_ready)
      valid_d = 1'b0;

    // Generators only advance on an accepted load, so dropped ticks leave no gap.
    if (load) begin
      for (int k = 0; k < CHANNELS; k++)
        data_d[k*WIDTH +: WIDTH] = lane0 + WIDTH'(k);
      ots_d   = ts_q;
      valid_d = 1'b1;
      lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
      inc_d   = inc_q + WIDTH'(1);
      walk_d  = {walk_q[WIDTH-2:0], walk_q[WIDTH-1]};
    end

    if (drop)
      ovr_d = 1'b1;
    else if (clr_ovr)
      ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ts_q    <= '0;
      lfsr_q  <= SEED;
      inc_q   <= '0;
      walk_q  <= WIDTH'(1);
      data_q  <= '0;
      ots_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      lfsr_q  <= lfsr_d;
      inc_q   <= inc_d;
      walk_q  <= walk_d;
      data_q  <= data_d;
      ots_q   <= ots_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_ts    = ots_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_data_gen_mc.sv
// Directed bench for data_gen_mc: three instances cover LFSR/back-pressure,
// increment wrap with three lanes, and PERIOD=1 walking-one/constant modes.
module tb_data_gen_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        en0, rdy0, clr0, v0, ov0;
  logic [1:0]  mode0;
  logic [7:0]  cv0;
  logic [15:0] d0;
  logic [31:0] ts0;

  logic        en1, rdy1, clr1, v1, ov1;
  logic [1:0]  mode1;
  logic [7:0]  cv1;
  logic [23:0] d1;
  logic [31:0] ts1;

  logic        en2, rdy2, clr2, v2, ov2;
  logic [1:0]  mode2;
  logic [7:0]  cv2;
  logic [15:0] d2;
  logic [31:0] ts2;

  data_gen_mc #(.PERIOD(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .mode(mode0), .const_val(cv0),
    .out_data(d0), .out_valid(v0), .out_ready(rdy0), .out_ts(ts0),
    .overrun(ov0), .clr_ovr(clr0));

  data_gen_mc #(.CHANNELS(3), .PERIOD(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .const_val(cv1),
    .out_data(d1), .out_valid(v1), .out_ready(rdy1), .out_ts(ts1),
    .overrun(ov1), .clr_ovr(clr1));

  data_gen_mc #(.PERIOD(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .const_val(cv2),
    .out_data(d2), .out_valid(v2), .out_ready(rdy2), .out_ts(ts2),
    .overrun(ov2), .clr_ovr(clr2));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en0 = 0; rdy0 = 1; clr0 = 0; mode0 = 2'd0; cv0 = 8'h00;
    en1 = 0; rdy1 = 1; clr1 = 0; mode1 = 2'd1; cv1 = 8'h00;
    en2 = 0; rdy2 = 1; clr2 = 0; mode2 = 2'd3; cv2 = 8'h00;
    cyc(2);
    check("rst_valid", v0, 0);
    check("rst_data", d0, 0);
    check("rst_ts", ts0, 0);
    check("rst_ovr", ov0, 0);

    // LFSR mode, free-flowing consumer
    rst_n = 1; en0 = 1;
    cyc(3);
    check("lfsr_pre_valid", v0, 0);
    cyc(1);
    check("lfsr1_valid", v0, 1);
    check("lfsr1_data", d0, 16'hA6A5);
    check("lfsr1_ts", ts0, 3);
    cyc(1);
    check("lfsr1_pulse", v0, 0);
    cyc(3);
    check("lfsr2_valid", v0, 1);
    check("lfsr2_data", d0, 16'hEBEA);
    check("lfsr2_ts", ts0, 7);
    cyc(4);
    check("lfsr3_data", d0, 16'h7675);
    check("lfsr3_ts", ts0, 11);

    // Back-pressure: ticks at edges 8 and 12 are dropped
    rst_n = 0;
    cyc(1);
    rst_n = 1;
    cyc(4);
    check("bp_load_data", d0, 16'hA6A5);
    rdy0 = 0;
    cyc(5);
    check("bp_ovr_set", ov0, 1);
    check("bp_hold_data", d0, 16'hA6A5);
    cyc(5);
    check("bp_hold_valid", v0, 1);
    check("bp_hold_data2", d0, 16'hA6A5);
    check("bp_hold_ts", ts0, 3);
    rdy0 = 1;
    cyc(1);
    check("bp_xfer_valid", v0, 0);
    check("bp_xfer_hold", d0, 16'hA6A5);
    cyc(1);
    check("bp_next_valid", v0, 1);
    check("bp_next_data", d0, 16'hEBEA);
    check("bp_next_ts", ts0, 15);

    // clr alone clears; clr coinciding with a drop loses to the set
    rdy0 = 0; clr0 = 1;
    cyc(1);
    clr0 = 0;
    check("clr_alone", ov0, 0);
    cyc(2);
    clr0 = 1;
    cyc(1);
    clr0 = 0;
    check("clr_vs_drop", ov0, 1);
    check("clr_hold_data", d0, 16'hEBEA);
    check("ar_pre_valid", v0, 1);

    // Async reset between edges
    rst_n = 0;
    #2;
    check("ar_valid", v0, 0);
    check("ar_data", d0, 0);
    check("ar_ts", ts0, 0);
    check("ar_ovr", ov0, 0);
    cyc(1);
    rdy0 = 1; rst_n = 1;
    cyc(4);
    check("ar_first_valid", v0, 1);
    check("ar_first_data", d0, 16'hA6A5);

    // Drop en at cnt=2; next tick PERIOD edges after re-enable
    cyc(2);
    en0 = 0;
    cyc(1);
    en0 = 1;
    cyc(1);
    check("en_no_early_tick", v0, 0);
    cyc(2);
    check("en_not_yet", v0, 0);
    cyc(1);
    check("en_reload_valid", v0, 1);
    check("en_reload_data", d0, 16'hEBEA);

    // Increment mode, three lanes, through the FF wrap
    en0 = 0;
    rst_n = 0;
    cyc(1);
    rst_n = 1; en1 = 1;
    cyc(4);
    check("inc1_data", d1, 24'h020100);
    cyc(4);
    check("inc2_data", d1, 24'h030201);
    cyc(4 * 254);
    check("inc_ff_data", d1, 24'h0100FF);
    check("inc_ff_ts", ts1, 1023);
    cyc(4);
    check("inc_wrap_data", d1, 24'h020100);

    // PERIOD=1: walking one, then constant, then walking resumes
    en1 = 0;
    rst_n = 0;
    cyc(1);
    rst_n = 1; en2 = 1;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] w;
      w = 8'(1 << (i % 8));
      cyc(1);
      check("walk_valid", v2, 1);
      check("walk_ch0", d2[7:0], w);
      check("walk_ch1", d2[15:8], w + 8'd1);
    end
    mode2 = 2'd2; cv2 = 8'h3C;
    cyc(1);
    check("const_valid", v2, 1);
    check("const_data", d2, 16'h3D3C);
    mode2 = 2'd3;
    cyc(1);
    check("walk_after_const", d2[7:0], 8'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_gen_mc.md
# data_gen_mc

Parametrised multi-channel stimulus/data generator for the team's non-integer-types and datapath exercise benches. It produces a new sample every `PERIOD` clock cycles on `CHANNELS` lanes of `WIDTH` bits each, in one of four generation modes, with a cycle-accurate timestamp. Samples leave through a valid/ready handshake with overrun detection. It replaces free-running `#delay`/`$random` generators with a synthesizable, reset-controlled, back-pressurable source.

## Interface
- `WIDTH`, 8, lane width in bits (4..32).
- `CHANNELS`, 2, number of output lanes (1..8).
- `PERIOD`, 10, clock cycles between samples (≥1).
- `SEED`, 8'hA5, initial LFSR state, WIDTH bits, must be nonzero.
- `POLY`, 8'hB8, Galois LFSR feedback mask, WIDTH bits.
- `TS_W`, 32, timestamp width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  enables the sample-period counter.
- `mode`  in  2  generation mode, sampled at the load edge.
- `const_val`  in  WIDTH  constant-mode value, sampled at the load edge.
- `out_data`  out  CHANNELS*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- `out_valid`  out  1  sample held and valid.
- `out_ready`  in  1  consumer accepts the sample.
- `out_ts`  out  TS_W  timestamp of the held sample.
- `overrun`  out  1  sticky flag: a sample was dropped.
- `clr_ovr`  in  1  clears `overrun`.

## Operation
- Reset (async, `rst_n`=0) sets the following, immediately and independent of `clk`:
  - outputs: `out_data`=0, `out_valid`=0, `out_ts`=0, `overrun`=0;
  - internal state: `cnt`=0, `ts`=0, `lfsr`=SEED, `inc`=0, `walk`=1.
- `ts` increments every cycle after reset, regardless of `en`, and wraps modulo 2^TS_W.
- `cnt` behaviour:
  - with `en`=1, it counts 0..PERIOD-1 and wraps to 0;
  - with `en`=0, it is forced to 0 and no tick occurs.
- Tick: `en`=1 and `cnt`=PERIOD-1.
- On a tick with slot free (`out_valid`=0, or `out_valid`&&`out_ready` in the same cycle), all of the following happen at that edge:
  - a new sample is loaded and `out_valid`=1;
  - `out_ts` captures the current (pre-increment) `ts`;
  - all generator states advance once.
- On a tick with slot busy (`out_valid`=1, `out_ready`=0):
  - the sample is dropped and `overrun`<=1;
  - generators do not advance;
  - the held sample and `out_ts` are unchanged.
- Lane 0 value by mode:
  - 0 = `lfsr`;
  - 1 = `inc`;
  - 2 = `const_val`;
  - 3 = `walk`.
- Lane k = lane0 + k, modulo 2^WIDTH.
- Generator advance, applied on every accepted load in all modes (independent of `mode`):
  - `lfsr` <= lsb ? (lfsr>>1)^POLY : lfsr>>1;
  - `inc` <= inc+1, wrapping;
  - `walk` <= rotate-left by 1.
- Handshake:
  - transfer on an edge with `out_valid`&&`out_ready`;
  - after a transfer with no simultaneous load, `out_valid`<=0 and `out_data` holds its last value;
  - `out_data`/`out_ts` must not change while `out_valid`=1 and `out_ready`=0.
- `overrun`:
  - cleared by `clr_ovr`;
  - if an overrun event and `clr_ovr` coincide, set wins.
- SEED=0 is illegal; the implementation carries an elaboration-time check.

## Timing
- `en` held high from cycle 0 with `cnt`=0: first load at edge PERIOD, then every PERIOD edges.
- `out_valid` rises the cycle after the load edge (registered). There is no combinational path from `out_ready` to `out_valid`/`out_data`.
- PERIOD=1 with `out_ready`=1: a load occurs every edge and `out_valid` stays high continuously.
- Dropping `en` mid-period discards partial progress. On re-enable, the next tick occurs PERIOD edges later.
- `rst_n` asserted mid-handshake: the held sample is lost. After `rst_n` rises, the first edge with `en`=1 starts from `cnt`=0.

## Test plan
- Async reset: assert `rst_n`=0 between clock edges while `out_valid`=1 and `overrun`=1 -> all outputs read 0 before the next edge. After release, first sample ch0=A5.
- LFSR, WIDTH=8, CHANNELS=2, PERIOD=4, mode 0, `out_ready`=1, `en`=1 from the first post-reset edge:
  - ch0 = A5, EA, 75; ch1 = A6, EB, 76;
  - `out_ts` = 3, 7, 11;
  - `out_valid` is a 1-cycle pulse every 4 cycles.
- Back-pressure, same config, `out_ready`=0 for 10 cycles after the first load:
  - A5 is held stable; 2 ticks are dropped and `overrun`=1;
  - after `out_ready`=1, the next sample is EA (generators did not advance on drops).
- Increment, mode 1, CHANNELS=3:
  - first two samples {00,01,02} and {01,02,03};
  - at `inc`=FF the sample is {FF,00,01}, and the next ch0 is 00.
- PERIOD=1, mode 3, `out_ready`=1:
  - `out_valid` stays 1 continuously;
  - ch0 walks 01,02,04,…,80,01.
  - Then switch to mode 2 with `const_val`=3C -> ch0=3C, ch1=3D on the next load.
- `clr_ovr` pulsed on the same edge as a drop -> `overrun` stays 1. `clr_ovr` alone -> 0 next cycle. Deassert `en` at `cnt`=2 then reassert -> next load exactly PERIOD edges later.
